iter_up_counter_ctrl: RTL and testbench

- Synchronous 6-bit loadable up-counter with a start/done handshake.
- Sequences iteration indices 0..N for the FPU's multi-cycle datapaths (divider, square-root, normalisation loops).
- Complements the existing loadable down counter. The down counter burns a loaded count toward zero; this block counts up from zero to a captured target and reports completion to the initiating control FSM.

---
 rtl/iter_up_counter_ctrl.sv | 88 ++++++++
 tb/tb_iter_up_counter_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iter_up_counter_ctrl.sv
// Up-counter from 0 to a captured target with a start/done handshake; Q registered, last/busy/done decode state.
// No backpressure: En stalls counting in RUN; optional sticky err on start-during-RUN when ITER_CNT_ERR_EN is defined.
module iter_up_counter_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             En,
    input  logic             abort,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             last,
    output logic             done
`ifdef ITER_CNT_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            Q     <= '0;
            tgt_q <= '0;
`ifdef ITER_CNT_ERR_EN
            err   <= 1'b0;
`endif
        end else if (abort) begin
            // Abort beats start and En; any start this cycle is dropped.
            state <= IDLE;
            Q     <= '0;
`ifdef ITER_CNT_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q <= target;
                        Q     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Increment is gated by the compare, so Q can never wrap.
                    if (En) begin
                        if (Q == tgt_q) begin
                            state <= DONE;
                        end else begin
                            Q <= Q + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        tgt_q <= target;
                        Q     <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef ITER_CNT_ERR_EN
            if (state == RUN && start) begin
                err <= 1'b1;
            end
`endif
        end
    end

    assign busy = (state == RUN);
    assign last = (state == RUN) && (Q == tgt_q);
    assign done = (state == DONE);

endmodule

// File: tb/tb_iter_up_counter_ctrl.sv
// Scoreboard bench for iter_up_counter_ctrl: directed steps queue expected outputs, a negedge monitor compares.
module tb_iter_up_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] target;
    logic       En;
    logic       abort;
    logic [5:0] Q;
    logic       busy;
    logic       last;
    logic       done;
`ifdef ITER_CNT_ERR_EN
    logic       err;
`endif

    iter_up_counter_ctrl #(.WIDTH(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .target (target),
        .En     (En),
        .abort  (abort),
        .Q      (Q),
        .busy   (busy),
        .last   (last),
        .done   (done)
`ifdef ITER_CNT_ERR_EN
        ,
        .err    (err)
`endif
    );

    typedef struct {
        int         id;
        logic [5:0] q;
        logic       busy;
        logic       last;
        logic       done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int id, input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %0d, expected %0d", id, name, act, req);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.id, "Q",    int'(Q),    int'(e.q));
                check(e.id, "busy", int'(busy), int'(e.busy));
                check(e.id, "last", int'(last), int'(e.last));
                check(e.id, "done", int'(done), int'(e.done));
`ifdef ITER_CNT_ERR_EN
                check(e.id, "err",  int'(err),  int'(e.err));
`endif
            end
        end
    end

    task automatic push(input int id, input logic [5:0] eq, input logic eb,
                        input logic el, input logic ed);
        exp_t e;
        e.id   = id;
        e.q    = eq;
        e.busy = eb;
        e.last = el;
        e.done = ed;
        e.err  = exp_err;
        exp_q.push_back(e);
    endtask

    // Apply inputs for one clock, then queue the outputs expected after that edge.
    task automatic step(input int id, input logic s, input logic [5:0] t, input logic e,
                        input logic a, input logic [5:0] eq, input logic eb,
                        input logic el, input logic ed);
        start  = s;
        target = t;
        En     = e;
        abort  = a;
        @(posedge clk);
        #1;
        push(id, eq, eb, el, ed);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        reset  = 1'b0;
        start  = 1'b0;
        target = 6'd0;
        En     = 1'b0;
        abort  = 1'b0;
        #1;
        push(0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // target=5, En held high; a target change mid-run must have no effect.
        step(100, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            step(100 + i, 1'b0, 6'd7, 1'b1, 1'b0, 6'(i), 1'b1, (i == 5), 1'b0);
        step(106, 1'b0, 6'd7, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 1'b1);
        step(107, 1'b0, 6'd7, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 1'b0);

        // target=0: one RUN cycle with last=1, then done.
        step(200, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        step(201, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        step(202, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        // target=63 with En toggling; a start at k=10 in RUN is ignored (and raises err).
        step(300, 1'b1, 6'd63, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 126; k++) begin
            if (k == 10) exp_err = 1'b1;
            step(300 + k, (k == 10), (k == 10) ? 6'd3 : 6'd63, k[0], 1'b0,
                 6'((k + 1) / 2), 1'b1, ((k + 1) / 2 == 63), 1'b0);
        end
        step(427, 1'b0, 6'd63, 1'b1, 1'b0, 6'd63, 1'b0, 1'b0, 1'b1);
        step(428, 1'b0, 6'd63, 1'b0, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start in the DONE cycle with the new target 2.
        step(500, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step(501, 1'b0, 6'd1, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        step(502, 1'b0, 6'd1, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b1);
        step(503, 1'b1, 6'd2, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step(504, 1'b0, 6'd1, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        step(505, 1'b0, 6'd1, 1'b1, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0);
        step(506, 1'b0, 6'd1, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b1);
        step(507, 1'b0, 6'd1, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0);

        // Abort together with start at Q=3: IDLE, Q=0, no done, start dropped.
        step(600, 1'b1, 6'd10, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++)
            step(600 + i, 1'b0, 6'd10, 1'b1, 1'b0, 6'(i), 1'b1, 1'b0, 1'b0);
        exp_err = 1'b0;
        step(604, 1'b1, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        step(605, 1'b0, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges at Q=4.
        step(700, 1'b1, 6'd10, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++)
            step(700 + i, 1'b0, 6'd10, 1'b1, 1'b0, 6'(i), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check(705, "async Q",    int'(Q),    0);
        check(705, "async busy", int'(busy), 0);
        check(705, "async last", int'(last), 0);
        check(705, "async done", int'(done), 0);
`ifdef ITER_CNT_ERR_EN
        check(705, "async err",  int'(err),  0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(706, 1'b0, 6'd10, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
